// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative HI/LO multiply/divide unit (shift-add mult, restoring div)
// Optional MDU_EARLY_OUT_EN: zero-magnitude operand completes one edge after start.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  input  logic             hilo_rd,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0]   opnd, opnd_nx;
  logic               is_div, is_div_nx;
  logic               neg_q, neg_q_nx;
  logic               neg_r, neg_r_nx;
  logic               div0, div0_nx;
  logic               done_nx;
  logic [WIDTH-1:0]   hi_r, hi_nx, lo_r, lo_nx;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_step, div_step, step, fin, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // acc low half holds the multiplier; upper half collects partial sums as it shifts right
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  // acc = {partial remainder, dividend bits still to shift in / quotient bits shifted out}
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  assign div_step  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign step = is_div ? div_step : mul_step;

`ifdef MDU_EARLY_OUT_EN
  logic hold, hold_nx;
  assign fin = hold ? acc : step;
`else
  assign fin = step;
`endif

  assign prod_fix = neg_q ? -fin : fin;
  assign q_fix    = neg_q ? -fin[WIDTH-1:0] : fin[WIDTH-1:0];
  assign r_fix    = neg_r ? -fin[2*WIDTH-1:WIDTH] : fin[2*WIDTH-1:WIDTH];

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    acc_nx    = acc;
    opnd_nx   = opnd;
    is_div_nx = is_div;
    neg_q_nx  = neg_q;
    neg_r_nx  = neg_r;
    div0_nx   = div0;
    done_nx   = 1'b0;
    hi_nx     = hi_r;
    lo_nx     = lo_r;
`ifdef MDU_EARLY_OUT_EN
    hold_nx   = hold;
`endif
    case (state)
      IDLE: begin
        if (hi_we) hi_nx = wd;
        if (lo_we) lo_nx = wd;
        if (start && !cancel) begin
          state_nx  = RUN;
          cnt_nx    = CW'(WIDTH);
          is_div_nx = op[1];
          opnd_nx   = op[1] ? b_mag : a_mag;
          acc_nx    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          neg_q_nx  = a_neg ^ b_neg;
          neg_r_nx  = a_neg;
          div0_nx   = op[1] & (b == '0);
`ifdef MDU_EARLY_OUT_EN
          hold_nx   = 1'b0;
          if (a == '0 || b == '0) begin
            hold_nx = 1'b1;
            cnt_nx  = CW'(1);
            acc_nx  = (op[1] && b == '0) ? {a_mag, {WIDTH{1'b1}}} : '0;
          end
`endif
        end
      end
      RUN: begin
        if (cancel) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          acc_nx = fin;
          cnt_nx = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            if (is_div) begin
              hi_nx = r_fix;
              lo_nx = div0 ? {WIDTH{1'b1}} : q_fix;
            end else begin
              hi_nx = prod_fix[2*WIDTH-1:WIDTH];
              lo_nx = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      done   <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
`ifdef MDU_EARLY_OUT_EN
      hold   <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      acc    <= acc_nx;
      opnd   <= opnd_nx;
      is_div <= is_div_nx;
      neg_q  <= neg_q_nx;
      neg_r  <= neg_r_nx;
      div0   <= div0_nx;
      done   <= done_nx;
      hi_r   <= hi_nx;
      lo_r   <= lo_nx;
`ifdef MDU_EARLY_OUT_EN
      hold   <= hold_nx;
`endif
    end
  end

  assign busy  = (state == RUN);
  assign stall = busy & (start | hilo_rd | hi_we | lo_we);
  assign hi    = hi_r;
  assign lo    = lo_r;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - scoreboard bench for mdu_iterative against an arithmetic model
module tb_mdu_iterative;

  localparam int W = 32;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we, hilo_rd, cancel;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  mdu_iterative #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .hilo_rd(hilo_rd), .cancel(cancel),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: 64-bit arithmetic; SV signed / and % truncate toward zero
  function automatic logic [63:0] model(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return ux * uy;
      2'd2: begin
        if (y == '0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == '0) return {x, 32'hFFFF_FFFF};
        return {32'(x % y), 32'(x / y)};
      end
    endcase
  endfunction

  function automatic int exp_lat(logic [W-1:0] x, logic [W-1:0] y);
    return (EARLY && (x == '0 || y == '0)) ? 1 : W;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        chk("result_hilo", {hi, lo}, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 64'(n), 64'(0));
  endtask

  task automatic issue(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back(model(o, x, y));
    tick();
    start = 1'b0;
  endtask

  task automatic run_op(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    int n;
    issue(o, x, y);
    chk("busy_after_start", 64'(busy), 64'(1));
    wait_done(n);
    chk("latency", 64'(n), 64'(exp_lat(x, y)));
    tick();
    chk("busy_after_done", 64'(busy), 64'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [W-1:0] hi0, lo0;
    int n;
    rst = 1'b1; start = 0; hi_we = 0; lo_we = 0; hilo_rd = 0; cancel = 0;
    op = 0; a = 0; b = 0; wd = 0;
    tick(); tick();
    chk("reset_state", {60'b0, busy, done, (hi != 0), (lo != 0)}, 64'b0);
    rst = 1'b0;
    tick();

    run_op(2'd0, 32'hFFFF_FFFD, 32'd7);
    run_op(2'd3, 32'd100, 32'd7);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd2, 32'd5, 32'd0);
    run_op(2'd3, 32'hFFFF_FFF0, 32'd0);
    run_op(2'd0, 32'd0, 32'h1234_5678);
    run_op(2'd2, 32'd0, 32'd9);

    // mthi/mtlo in IDLE: both at once, no stall while idle
    hi_we = 1; lo_we = 1; wd = 32'hCAFE_F00D; start = 1; cancel = 1;
    #1 chk("stall_idle", 64'(stall), 64'(0));
    tick();
    hi_we = 0; lo_we = 0; start = 0; cancel = 0;
    chk("cancel_start_idle", 64'(busy), 64'(0));
    chk("write_both", {hi, lo}, {2{32'hCAFE_F00D}});

    // write on the same edge as start: write lands, then the op overwrites
    hi_we = 1; lo_we = 1; wd = 32'hDEAD_BEEF;
    issue(2'd1, 32'd9, 32'd9);
    hi_we = 0; lo_we = 0;
    chk("write_with_start", {hi, lo}, {2{32'hDEAD_BEEF}});
    wait_done(n);
    tick();

    // contention while busy: all requests stall and none take effect
    issue(2'd1, 32'h0001_0003, 32'h0002_0005);
    repeat (4) tick();
    hi0 = hi; lo0 = lo;
    start = 1; hilo_rd = 1; lo_we = 1; wd = 32'h1234; op = 2'd0; a = 1; b = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_busy", 64'(stall), 64'(1));
      tick();
      chk("hold_hilo", {hi, lo}, {hi0, lo0});
    end
    start = 0; hilo_rd = 0; lo_we = 0;
    wait_done(n);
    tick();
    chk("no_restart", 64'(busy), 64'(0));

    // cancel mid-divide: HI/LO untouched and no done pulse
    hi_we = 1; wd = 32'hAAAA; tick(); hi_we = 0;
    lo_we = 1; wd = 32'h5555; tick(); lo_we = 0;
    op = 2'd2; a = 32'd1000; b = 32'd3; start = 1;
    tick();
    start = 0;
    repeat (9) tick();
    cancel = 1;
    tick();
    cancel = 0;
    chk("cancel_busy", 64'(busy), 64'(0));
    chk("cancel_hilo", {hi, lo}, {32'hAAAA, 32'h5555});
    repeat (W + 2) tick();
    chk("cancel_hilo_later", {hi, lo}, {32'hAAAA, 32'h5555});

    // start coinciding with the final iteration edge is ignored
    issue(2'd2, 32'd50, 32'd7);
    repeat (W - 1) tick();
    start = 1; op = 2'd1; a = 32'd3; b = 32'd3;
    tick();
    start = 0;
    chk("final_edge_done", 64'(done), 64'(1));
    chk("final_edge_start_ignored", 64'(busy), 64'(0));
    tick();

    // asynchronous reset mid-multiply
    issue(2'd0, 32'd12345, 32'd678);
    repeat (11) tick();
    #2 rst = 1;
    #1 chk("async_reset", {60'b0, busy, done, (hi != 0), (lo != 0)}, 64'b0);
    sb_q.delete();
    tick();
    rst = 0;
    tick();
    run_op(2'd0, 32'd6, 32'd7);

    for (int i = 0; i < 40; i++) run_op(2'($urandom_range(0, 3)), pick(), pick());

    repeat (3) tick();
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
